// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel scan controller: pixel/window widths,
// controller FSM states and kernel window byte indices.
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_N = 8;
  localparam int WIN_W = PIX_W * WIN_N;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Window byte positions; the centre pixel is never sent to the kernel.
  localparam int IDX_TL = 0;
  localparam int IDX_TC = 1;
  localparam int IDX_TR = 2;
  localparam int IDX_ML = 3;
  localparam int IDX_MR = 4;
  localparam int IDX_BL = 5;
  localparam int IDX_BC = 6;
  localparam int IDX_BR = 7;

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage: single shared address, read-before-write
// (the read returns the value stored before this cycle's write).
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         wdata,
  output logic [PIX_W-1:0]         rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Streaming 3x3 Sobel window scheduler with start/busy/done framing.
// Optional edge pixel counter enabled by defining SOBEL_CTRL_STATS_EN.
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int KLAT  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [PIX_W-1:0]                s_pix,
  output logic [WIN_W-1:0]                k_win,
  input  logic                            k_result,
  output logic                            m_valid,
  output logic                            m_bin,
  output logic [$clog2(IMG_W)-1:0]        m_x,
  output logic [$clog2(IMG_H)-1:0]        m_y,
  output logic [$clog2(IMG_W*IMG_H):0]    edge_cnt
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int DW = $clog2(KLAT + 2);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [DW-1:0] D_LAST = DW'(KLAT);

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [DW-1:0]   dcnt;
  logic            hs;
  logic            emit;
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic [PIX_W-1:0] top_d1, top_d2, mid_d1, mid_d2, bot_d1, bot_d2;
  logic [KLAT:0]   vld_pipe;
  logic [XW-1:0]   x_pipe [KLAT+1];
  logic [YW-1:0]   y_pipe [KLAT+1];

  assign hs   = s_valid & s_ready;
  assign emit = hs && (x >= XW'(2)) && (y >= YW'(2));

  // Cascaded lines: lb0 holds row y-1, lb1 receives what lb0 held (row y-2).
  sobel_line_buf #(.DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .we   (hs),
    .addr (x),
    .wdata(s_pix),
    .rdata(lb0_q)
  );

  sobel_line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .we   (hs),
    .addr (x),
    .wdata(lb0_q),
    .rdata(lb1_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_ready <= 1'b0;
      x       <= '0;
      y       <= '0;
      dcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            s_ready <= 1'b1;
            x       <= '0;
            y       <= '0;
          end
        end
        RUN: begin
          if (hs) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                state   <= DRAIN;
                s_ready <= 1'b0;
                dcnt    <= '0;
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      top_d1 <= lb1_q;
      top_d2 <= top_d1;
      mid_d1 <= lb0_q;
      mid_d2 <= mid_d1;
      bot_d1 <= s_pix;
      bot_d2 <= bot_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_win <= '0;
    end else if (hs) begin
      k_win[IDX_TL*PIX_W +: PIX_W] <= top_d2;
      k_win[IDX_TC*PIX_W +: PIX_W] <= top_d1;
      k_win[IDX_TR*PIX_W +: PIX_W] <= lb1_q;
      k_win[IDX_ML*PIX_W +: PIX_W] <= mid_d2;
      k_win[IDX_MR*PIX_W +: PIX_W] <= lb0_q;
      k_win[IDX_BL*PIX_W +: PIX_W] <= bot_d2;
      k_win[IDX_BC*PIX_W +: PIX_W] <= bot_d1;
      k_win[IDX_BR*PIX_W +: PIX_W] <= s_pix;
    end
  end

  // Stage 0 lines up with k_win; the last stage lines up with k_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < KLAT + 1; i++) begin
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= emit;
      x_pipe[0]   <= x - XW'(1);
      y_pipe[0]   <= y - YW'(1);
      for (int unsigned i = 1; i < KLAT + 1; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        x_pipe[i]   <= x_pipe[i-1];
        y_pipe[i]   <= y_pipe[i-1];
      end
    end
  end

  assign m_valid = vld_pipe[KLAT];
  assign m_x     = x_pipe[KLAT];
  assign m_y     = y_pipe[KLAT];
  assign m_bin   = m_valid & k_result;

`ifdef SOBEL_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (state == IDLE && start) begin
      edge_cnt <= '0;
    end else if (m_valid && m_bin) begin
      edge_cnt <= edge_cnt + ($bits(edge_cnt))'(1);
    end
  end
`else
  assign edge_cnt = '0;
`endif

endmodule
